// File: rtl/priority_enc_rr.sv
// Fixed-priority / round-robin request encoder; grant registered 1 cycle after request.
// Backpressure: a grant is held stable until ack, then one IDLE arbitration cycle follows.
module priority_enc_rr #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         mode,
    input  logic         ack,
    output logic [W-1:0] out,
    output logic [N-1:0] grant,
    output logic         v
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [W:0]   N_L  = (W+1)'(N);
    localparam logic [W-1:0] N_M1 = W'(N - 1);

    state_t       state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [N-1:0] grant_q, grant_d;
    logic         v_q, v_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         rr_q, rr_d;

    logic [W-1:0] fix_win, rr_win, win;
    logic [N-1:0] win_oh;
    logic [W:0]   idx;
    logic         rr_found;

    always_comb begin
        fix_win  = '0;
        rr_win   = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            if (d[k]) fix_win = W'(k);
        end
        // Search upward from ptr; the index is wrapped explicitly so non-power-of-two N stays in range.
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (W+1)'(i);
            if (idx >= N_L) idx = idx - N_L;
            if (!rr_found && d[idx[W-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = idx[W-1:0];
            end
        end
        win         = mode ? rr_win : fix_win;
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        grant_d = grant_q;
        v_d     = v_q;
        ptr_d   = ptr_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (|d) begin
                    out_d   = win;
                    grant_d = win_oh;
                    v_d     = 1'b1;
                    rr_d    = mode;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    v_d     = 1'b0;
                    grant_d = '0;
                    state_d = IDLE;
                    // rr_q remembers the mode the grant was won under.
                    if (rr_q) ptr_d = (out_q == N_M1) ? '0 : out_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            grant_q <= '0;
            v_q     <= 1'b0;
            ptr_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            grant_q <= grant_d;
            v_q     <= v_d;
            ptr_q   <= ptr_d;
            rr_q    <= rr_d;
        end
    end

    assign out   = out_q;
    assign grant = grant_q;
    assign v     = v_q;

endmodule

// File: tb/tb_priority_enc_rr.sv
// Bench for priority_enc_rr (N = 8): directed scenarios then random traffic, checked by a scoreboard.
module tb_priority_enc_rr;
    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] d = '0;
    logic         mode = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] out;
    logic [N-1:0] grant;
    logic         v;

    priority_enc_rr #(.N(N)) dut (
        .clk(clk), .rst(rst), .d(d), .mode(mode), .ack(ack),
        .out(out), .grant(grant), .v(v)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, updated at each rising edge from the inputs sampled there.
    bit m_known   = 0;
    bit m_busy    = 0;
    bit m_gmode   = 0;
    int m_ptr     = 0;
    int m_win     = 0;
    int m_lastout = 0;
    int exp_q[$];

    function automatic int pick(input logic [N-1:0] req, input bit rr, input int p);
        int w;
        w = -1;
        if (!rr) begin
            for (int k = N - 1; k >= 0; k--) if (req[k] && w < 0) w = k;
        end else begin
            for (int i = 0; i < N; i++) if (req[(p + i) % N] && w < 0) w = (p + i) % N;
        end
        return w;
    endfunction

    task automatic step(input logic [N-1:0] dd, input bit mm, input bit aa, input bit rr_);
        d = dd; mode = mm; ack = aa; rst = rr_;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_lastout = 0; m_known = 1;
        end else if (m_known) begin
            if (!m_busy) begin
                if (d != 0) begin
                    m_win = pick(d, mode, m_ptr);
                    m_gmode = mode;
                    m_busy = 1;
                    m_lastout = m_win;
                    exp_q.push_back(m_win);
                end
            end else if (ack) begin
                m_busy = 0;
                if (m_gmode) m_ptr = (m_win + 1) % N;
            end
        end
        #1;
    endtask

    bit v_prev = 0;
    int cur_out = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            check("valid", int'(v), int'(m_busy));
            if (v && !v_prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant: got out=%0d expected no grant", out);
                end else begin
                    cur_out = exp_q.pop_front();
                    check("grant_out", int'(out), cur_out);
                    check("grant_onehot", int'(grant), 1 << cur_out);
                end
            end else if (v) begin
                check("hold_out", int'(out), cur_out);
                check("hold_onehot", int'(grant), 1 << cur_out);
            end else begin
                check("idle_out", int'(out), m_lastout);
                check("idle_grant", int'(grant), 0);
            end
            v_prev = v;
        end
    end

    initial begin
        // Reset with all lines requesting, then release into fixed priority.
        step(8'hFF, 0, 0, 1);
        step(8'hFF, 0, 0, 1);
        step(8'hFF, 0, 0, 0);
        step(8'hFF, 0, 1, 0);
        // Fixed priority; dropping requests while granted must not move the grant.
        step(8'b0010_0110, 0, 0, 0);
        repeat (3) step(8'h01, 0, 0, 0);
        step(8'h01, 0, 1, 0);
        step(8'h00, 0, 0, 0);
        // Round-robin sweep from ptr 0 with everyone requesting.
        step(8'h00, 0, 0, 1);
        repeat (9) begin
            step(8'hFF, 1, 0, 0);
            step(8'hFF, 1, 1, 0);
        end
        // Wrap from ptr 6 down to line 0, then on to line 1.
        step(8'h00, 0, 0, 1);
        repeat (6) begin
            step(8'hFF, 1, 0, 0);
            step(8'hFF, 1, 1, 0);
        end
        step(8'b0000_0011, 1, 0, 0);
        step(8'b0000_0011, 1, 1, 0);
        step(8'b0000_0011, 1, 0, 0);
        step(8'b0000_0011, 1, 1, 0);
        // Reset wins over ack while holding line 3.
        step(8'h00, 0, 0, 1);
        repeat (3) begin
            step(8'hFF, 1, 0, 0);
            step(8'hFF, 1, 1, 0);
        end
        step(8'hFF, 1, 0, 0);
        step(8'hFF, 1, 1, 1);
        step(8'hFF, 1, 0, 0);
        step(8'hFF, 1, 1, 0);
        // Idle with ack toggling must do nothing.
        for (int i = 0; i < 5; i++) step(8'h00, 1, i[0], 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step(N'($urandom), 1'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
        step(8'h00, 0, 1, 0);
        step(8'h00, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_grants: got %0d undelivered expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
